// File: rtl/center_stream.sv
// center_stream: buffers one N_CH x N_SAMP frame and computes each channel's
// mean. It then streams every sample minus its channel mean, in input order.
// Build option: define CENTER_SAT_EN to saturate the difference to DATA_W.
// When it is undefined, the difference wraps to its DATA_W least significant bits.
module center_stream #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned N_SAMP = 8,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned SH     = $clog2(N_SAMP);
  localparam int unsigned ACC_W  = DATA_W + SH;
  localparam int unsigned TOTAL  = N_CH * N_SAMP;
  localparam int unsigned ADDR_W = $clog2(TOTAL);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {StLoad, StMean, StDrain} state_e;

  state_e                  state_q, state_d;
  logic                    rdy_q;
  logic [ADDR_W-1:0]       wr_cnt_q;
  logic [CH_W-1:0]         mean_cnt_q;
  logic [CNT_W-1:0]        rd_cnt_q;
  logic signed [ACC_W-1:0] sum_q [N_CH];
  logic [DATA_W-1:0]       mean_q [N_CH];
  logic [DATA_W-1:0]       buf_mem [TOTAL];

  // Read stage: holds the sample fetched one cycle ahead of the output register.
  logic                    rd_vld_q;
  logic [DATA_W-1:0]       rd_data_q;
  logic [CH_W-1:0]         rd_ch_q;
  logic                    rd_last_q;

  logic                    out_valid_q;
  logic [DATA_W-1:0]       out_data_q;
  logic [CH_W-1:0]         out_ch_q;
  logic                    out_last_q;

  logic                    in_fire, wr_last, mean_last, advance, issue, frame_done;
  logic [CH_W-1:0]         wr_ch;
  logic signed [ACC_W-1:0] in_ext;
  logic [DATA_W-1:0]       rd_mean, diff_res;

  // rdy_q keeps in_ready low for the first cycle after reset release.
  assign in_ready   = (state_q == StLoad) && rdy_q;
  assign in_fire    = in_valid && in_ready;
  assign wr_last    = wr_cnt_q == ADDR_W'(TOTAL - 1);
  assign wr_ch      = CH_W'(wr_cnt_q >> SH);
  assign in_ext     = {{SH{in_data[DATA_W-1]}}, in_data};
  assign mean_last  = mean_cnt_q == CH_W'(N_CH - 1);
  // Both pipeline stages move together whenever the output register can take data.
  assign advance    = (state_q == StDrain) && (!out_valid_q || out_ready);
  assign issue      = advance && (rd_cnt_q < CNT_W'(TOTAL));
  assign frame_done = (state_q == StDrain) && out_valid_q && out_ready && out_last_q;
  assign rd_mean    = mean_q[rd_ch_q];

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_last   = out_last_q;
  assign busy       = !((state_q == StLoad) && (wr_cnt_q == '0));

`ifdef CENTER_SAT_EN
  logic [DATA_W:0] diff;

  // Subtract in DATA_W+1 bits and clamp when the result leaves the DATA_W range.
  always_comb begin
    diff = {rd_data_q[DATA_W-1], rd_data_q} - {rd_mean[DATA_W-1], rd_mean};
    if (diff[DATA_W] != diff[DATA_W-1]) begin
      diff_res = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      diff_res = diff[DATA_W-1:0];
    end
  end
`else
  assign diff_res = rd_data_q - rd_mean;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StLoad;
    else        state_q <= state_d;
  end

  // Next-state logic: LOAD -> MEAN -> DRAIN -> LOAD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (in_fire && wr_last) state_d = StMean;
      StMean:  if (mean_last) state_d = StDrain;
      StDrain: if (frame_done) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // Frame buffer write; contents need no reset since each frame overwrites all entries.
  always_ff @(posedge clk) begin
    if (in_fire) buf_mem[wr_cnt_q] <= in_data;
  end

  // Load counter, per-channel sums and the one-channel-per-cycle mean computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      wr_cnt_q   <= '0;
      mean_cnt_q <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        sum_q[i]  <= '0;
        mean_q[i] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (in_fire) begin
        sum_q[wr_ch] <= sum_q[wr_ch] + in_ext;
        wr_cnt_q     <= wr_last ? '0 : wr_cnt_q + 1'b1;
      end
      if (state_q == StMean) begin
        // Arithmetic shift floors toward -inf; the mean always fits in DATA_W.
        mean_q[mean_cnt_q] <= DATA_W'(sum_q[mean_cnt_q] >>> SH);
        mean_cnt_q         <= mean_last ? '0 : mean_cnt_q + 1'b1;
      end
      if (frame_done) begin
        for (int i = 0; i < int'(N_CH); i++) sum_q[i] <= '0;
      end
    end
  end

  // Drain pipeline: buffer read stage feeding the registered, stallable output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_data_q   <= '0;
      rd_ch_q     <= '0;
      rd_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else if (advance) begin
      out_valid_q <= rd_vld_q;
      out_data_q  <= diff_res;
      out_ch_q    <= rd_ch_q;
      out_last_q  <= rd_last_q && rd_vld_q;
      rd_vld_q    <= issue;
      if (issue) begin
        rd_data_q <= buf_mem[rd_cnt_q[ADDR_W-1:0]];
        rd_ch_q   <= CH_W'(rd_cnt_q >> SH);
        rd_last_q <= rd_cnt_q == CNT_W'(TOTAL - 1);
        rd_cnt_q  <= rd_cnt_q + 1'b1;
      end
      if (frame_done) rd_cnt_q <= '0;
    end
  end

endmodule
